// File: rtl/amp_cfg_pkg.sv
// Shared definitions for the amplifier SPI configuration writer: FSM states,
// frame field positions and the default register table.
package amp_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_GAP,
        ST_DONE,
        ST_RB_SETUP,
        ST_RB_SHIFT,
        ST_RB_HOLD,
        ST_RB_GAP
    } cfg_state_e;

    localparam int unsigned RW_BIT   = 15;
    localparam int unsigned ADDR_MSB = 14;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;

    function automatic logic [15:0] default_word(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'h0103;
            4'd1:    return 16'h0240;
            4'd2:    return 16'h0310;
            4'd3:    return 16'h0401;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [7:0] frame_data(input logic [15:0] w);
        return w[DATA_MSB:DATA_LSB];
    endfunction

    function automatic logic [6:0] frame_addr(input logic [15:0] w);
        return w[ADDR_MSB:ADDR_LSB];
    endfunction

    // Read-back frame: same address, R/nW set, data byte zeroed.
    function automatic logic [15:0] read_frame(input logic [15:0] w);
        logic [15:0] rf;
        rf                    = '0;
        rf[RW_BIT]            = 1'b1;
        rf[ADDR_MSB:ADDR_LSB] = frame_addr(w);
        return rf;
    endfunction

endpackage

// File: rtl/amp_config_rom.sv
// Combinational configuration table: word index -> SPI frame.
module amp_config_rom
    import amp_cfg_pkg::*;
#(
    parameter int unsigned IDX_W  = 2,
    parameter int unsigned WORD_W = 16
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [WORD_W-1:0] word
);

    always_comb begin
        word = WORD_W'(default_word(4'(idx)));
    end

endmodule

// File: rtl/amp_config_spi.sv
// Writes the configuration table to the amplifier over SPI mode 0 on a rising
// edge of send_config_in. Optional read-back verification: AMP_CFG_READBACK_EN.
module amp_config_spi
    import amp_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned WORD_W    = 16
) (
    input  logic clk_in,
    input  logic resetb,
    input  logic send_config_in,
    input  logic spi_miso_in,
    output logic spi_csn_out,
    output logic spi_sclk_out,
    output logic spi_mosi_out,
    output logic cfg_busy_out,
    output logic cfg_done_out,
    output logic cfg_error_out
);

    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned CNT_W = $clog2(2 * CLK_DIV) + 1;
    localparam int unsigned BIT_W = $clog2(WORD_W);

    localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    cfg_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              abort_q, abort_d;
    logic              send_q, send_prev_q;
    logic              start;
    logic              stop;
    logic              cs_active_d;
    logic              sclk_d;
    logic [WORD_W-1:0] rom_word;

    amp_config_rom #(
        .IDX_W  (IDX_W),
        .WORD_W (WORD_W)
    ) u_rom (
        .idx  (idx_q),
        .word (rom_word)
    );

    assign start = send_q & ~send_prev_q;
    assign stop  = abort_q | ~send_q;

`ifdef AMP_CFG_READBACK_EN
    logic [7:0] rx_q, rx_d;
    logic       err_q, err_d;
`else
    logic unused_miso;
    assign unused_miso = spi_miso_in;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        abort_d = abort_q;
`ifdef AMP_CFG_READBACK_EN
        rx_d    = rx_q;
        err_d   = err_q;
`endif
        if (state_q != ST_IDLE && state_q != ST_DONE && !send_q)
            abort_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                idx_d   = '0;
                abort_d = 1'b0;
                if (start) begin
                    state_d = ST_LOAD;
`ifdef AMP_CFG_READBACK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                shreg_d = rom_word;
                cnt_d   = '0;
                state_d = ST_CS_SETUP;
            end
            ST_CS_SETUP, ST_RB_SETUP: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = (state_q == ST_CS_SETUP) ? ST_SHIFT : ST_RB_SHIFT;
                end
            end
            ST_SHIFT, ST_RB_SHIFT: begin
`ifdef AMP_CFG_READBACK_EN
                // MISO is captured on the clk edge that raises SCLK.
                if (state_q == ST_RB_SHIFT && cnt_q == HALF &&
                    bit_q >= BIT_W'(WORD_W - 8))
                    rx_d = {rx_q[6:0], spi_miso_in};
                if (state_q == ST_RB_SHIFT && cnt_q == FULL && bit_q == LAST_BIT &&
                    rx_q != frame_data(16'(rom_word)))
                    err_d = 1'b1;
`endif
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT)
                        state_d = (state_q == ST_SHIFT) ? ST_CS_HOLD : ST_RB_HOLD;
                end
            end
            ST_CS_HOLD, ST_RB_HOLD: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = (state_q == ST_CS_HOLD) ? ST_GAP : ST_RB_GAP;
                end
            end
            ST_GAP, ST_RB_GAP: begin
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    if (stop) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
`ifdef AMP_CFG_READBACK_EN
                    end else if (state_q == ST_GAP) begin
                        shreg_d = WORD_W'(read_frame(16'(rom_word)));
                        state_d = ST_RB_SETUP;
`endif
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                cnt_d = '0;
                if (!send_q) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cs_active_d = (state_d == ST_CS_SETUP) || (state_d == ST_SHIFT) ||
                      (state_d == ST_CS_HOLD)  || (state_d == ST_RB_SETUP) ||
                      (state_d == ST_RB_SHIFT) || (state_d == ST_RB_HOLD);
        sclk_d      = ((state_d == ST_SHIFT) || (state_d == ST_RB_SHIFT)) && (cnt_d > HALF);
    end

    // Pin registers are loaded from next-state values so they align with state_q.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            idx_q        <= '0;
            shreg_q      <= '0;
            abort_q      <= 1'b0;
            send_q       <= 1'b0;
            send_prev_q  <= 1'b0;
            spi_csn_out  <= 1'b1;
            spi_sclk_out <= 1'b0;
            spi_mosi_out <= 1'b0;
            cfg_busy_out <= 1'b0;
            cfg_done_out <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            abort_q      <= abort_d;
            send_q       <= send_config_in;
            send_prev_q  <= send_q;
            spi_csn_out  <= ~cs_active_d;
            spi_sclk_out <= sclk_d;
            spi_mosi_out <= cs_active_d & shreg_d[WORD_W-1];
            cfg_busy_out <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            cfg_done_out <= (state_d == ST_DONE);
        end
    end

`ifdef AMP_CFG_READBACK_EN
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            rx_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rx_q  <= rx_d;
            err_q <= err_d;
        end
    end

    assign cfg_error_out = err_q;
`else
    assign cfg_error_out = 1'b0;
`endif

endmodule
